hazard_ctrl: RTL and testbench

//  Central hazard/stall scheduler for the 5-stage RV32I pipeline.

---
 rtl/pipeline_pkg.sv | 51 +++++
 rtl/hazard_ctrl_sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32I pipeline hazard logic: result-select codes,
// forwarding mux selects, hazard FSM states and the stall/flush control bundle.
package pipeline_pkg;

    localparam logic [2:0] RES_MEM = 3'b001;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FAULT    = 2'b10
    } hz_state_e;

    typedef struct packed {
        logic stallf;
        logic stalld;
        logic stalle;
        logic stallm;
        logic flushd;
        logic flushe;
        logic flushw;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE = '0;

    // Source-operand forwarding select; the M stage holds the younger result,
    // so it wins over W. Register x0 is hard-wired to zero and never forwards.
    function automatic fwd_e fwd_select(
        input logic regwrite_m,
        input logic regwrite_w,
        input logic rdm_hit,
        input logic rdw_hit,
        input logic rdm_zero,
        input logic rdw_zero
    );
        fwd_e sel;
        sel = FWD_RF;
        if (regwrite_m && !rdm_zero && rdm_hit) begin
            sel = FWD_MEM;
        end else if (regwrite_w && !rdw_zero && rdw_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clr has priority.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall scheduler for the 5-stage RV32I pipeline: operand forwarding,
// load-use bubbles, redirect flushes, data-memory waits with a timeout fault.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_FILE_ADDR_WIDTH = 5,
    parameter int TIMEOUT             = 255,
    parameter int CNT_WIDTH           = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rs1d,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rs2d,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rs1e,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rs2e,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rde,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rdm,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rdw,
    input  logic                           regwritem,
    input  logic                           regwritew,
    input  logic [2:0]                     resultsrce,
    input  logic                           pcsrce,
    input  logic                           memreqm,
    input  logic                           memreadym,
    output logic [1:0]                     forwardae,
    output logic [1:0]                     forwardbe,
    output logic                           stallf,
    output logic                           stalld,
    output logic                           stalle,
    output logic                           stallm,
    output logic                           flushd,
    output logic                           flushe,
    output logic                           flushw,
    output logic                           memerr,
    output logic [CNT_WIDTH-1:0]           stall_cnt,
    output logic [CNT_WIDTH-1:0]           flush_cnt
);

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W:0] TIMEOUT_CMP = (WAIT_W + 1)'(TIMEOUT);

    hz_state_e                r_state;
    hz_state_e                w_state_next;
    logic [WAIT_W-1:0]        r_wait_cnt;
    logic [WAIT_W-1:0]        w_wait_next;
    logic [WAIT_W:0]          w_wait_inc;
    logic                     r_memerr;
    logic                     w_memerr_next;
    hz_ctrl_t                 w_ctrl;
    logic                     w_redirect;
    logic                     w_memwait;
    logic                     w_lwstall;
    logic [REG_FILE_ADDR_WIDTH-1:0] w_rs_e [2];
    fwd_e                     w_fwd [2];

    assign w_rs_e[0] = rs1e;
    assign w_rs_e[1] = rs2e;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd[gi] = fwd_select(regwritem, regwritew,
                                          rdm == w_rs_e[gi], rdw == w_rs_e[gi],
                                          rdm == '0, rdw == '0);
        end
    endgenerate

    assign forwardae = rst ? FWD_RF : w_fwd[0];
    assign forwardbe = rst ? FWD_RF : w_fwd[1];

    assign w_lwstall  = (resultsrce == RES_MEM) && (rde != '0) && ((rde == rs1d) || (rde == rs2d));
    assign w_memwait  = memreqm && !memreadym;
    assign w_wait_inc = {1'b0, r_wait_cnt} + (WAIT_W + 1)'(1);

    // Next-state logic: the timeout trips on the wait cycle whose increment
    // would bring the counter to TIMEOUT.
    always_comb begin
        w_state_next  = r_state;
        w_wait_next   = r_wait_cnt;
        w_memerr_next = r_memerr;
        case (r_state)
            RUN: begin
                w_wait_next = '0;
                if (w_memwait) begin
                    w_state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                w_wait_next = w_wait_inc[WAIT_W-1:0];
                if (memreadym) begin
                    w_state_next = RUN;
                    w_wait_next  = '0;
                end else if (w_wait_inc >= TIMEOUT_CMP) begin
                    w_state_next  = FAULT;
                    w_memerr_next = 1'b1;
                end
            end
            FAULT: begin
                w_state_next = FAULT;
            end
            default: begin
                w_state_next = RUN;
                w_wait_next  = '0;
            end
        endcase
    end

    // Output priority: reset, fault, memory wait, redirect, load-use bubble.
    always_comb begin
        w_ctrl     = CTRL_NONE;
        w_redirect = 1'b0;
        if (rst) begin
            w_ctrl.flushd = 1'b1;
            w_ctrl.flushe = 1'b1;
            w_ctrl.flushw = 1'b1;
        end else if ((r_state == FAULT) || w_memwait) begin
            w_ctrl.stallf = 1'b1;
            w_ctrl.stalld = 1'b1;
            w_ctrl.stalle = 1'b1;
            w_ctrl.stallm = 1'b1;
            w_ctrl.flushw = 1'b1;
        end else if (pcsrce) begin
            w_ctrl.flushd = 1'b1;
            w_ctrl.flushe = 1'b1;
            w_redirect    = 1'b1;
        end else if (w_lwstall) begin
            w_ctrl.stallf = 1'b1;
            w_ctrl.stalld = 1'b1;
            w_ctrl.flushe = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_memerr   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            r_memerr   <= w_memerr_next;
        end
    end

    assign stallf = w_ctrl.stallf;
    assign stalld = w_ctrl.stalld;
    assign stalle = w_ctrl.stalle;
    assign stallm = w_ctrl.stallm;
    assign flushd = w_ctrl.flushd;
    assign flushe = w_ctrl.flushe;
    assign flushw = w_ctrl.flushw;
    assign memerr = r_memerr;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_inc   (w_ctrl.stallf),
        .o_count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_inc   (w_redirect),
        .o_count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with a short timeout and a 3-bit
// counter so that fault and saturation behaviour are reachable quickly.
module tb_hazard_ctrl;
    import pipeline_pkg::*;

    localparam int RW  = 5;
    localparam int TO  = 4;
    localparam int CW  = 3;

    localparam int unsigned C_NONE = 7'b0000000;
    localparam int unsigned C_RST  = 7'b0000111;
    localparam int unsigned C_LW   = 7'b1100010;
    localparam int unsigned C_BR   = 7'b0000110;
    localparam int unsigned C_MW   = 7'b1111001;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic          regwritem, regwritew, pcsrce, memreqm, memreadym;
    logic [2:0]    resultsrce;
    logic [1:0]    forwardae, forwardbe;
    logic          stallf, stalld, stalle, stallm, flushd, flushe, flushw, memerr;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.REG_FILE_ADDR_WIDTH(RW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e),
        .rde(rde), .rdm(rdm), .rdw(rdw),
        .regwritem(regwritem), .regwritew(regwritew),
        .resultsrce(resultsrce), .pcsrce(pcsrce),
        .memreqm(memreqm), .memreadym(memreadym),
        .forwardae(forwardae), .forwardbe(forwardbe),
        .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm),
        .flushd(flushd), .flushe(flushe), .flushw(flushw),
        .memerr(memerr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {S_FWDA, S_FWDB, S_CTRL, S_MEMERR, S_SCNT, S_FCNT} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        int unsigned val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int unsigned observe(sel_e s);
        case (s)
            S_FWDA:   return int'(forwardae);
            S_FWDB:   return int'(forwardbe);
            S_CTRL:   return int'({stallf, stalld, stalle, stallm, flushd, flushe, flushw});
            S_MEMERR: return int'(memerr);
            S_SCNT:   return int'(stall_cnt);
            default:  return int'(flush_cnt);
        endcase
    endfunction

    task automatic exp_push(input string tag, input sel_e s, input int unsigned v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        int unsigned obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Sample on the falling edge, then advance past the next rising edge.
    task automatic step(input string name);
        @(negedge clk);
        check_all();
        $display("step %-12s t=%0t checks=%0d", name, $time, checks);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0;
        rde = '0; rdm = '0; rdw = '0;
        regwritem = 1'b0; regwritew = 1'b0;
        resultsrce = 3'b000; pcsrce = 1'b0;
        memreqm = 1'b0; memreadym = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset overrides forwarding and drives the flushes
        rdm = 5; regwritem = 1'b1; rs1e = 5;
        exp_push("rst_ctrl", S_CTRL, C_RST);
        exp_push("rst_fwda", S_FWDA, 2'b00);
        step("reset");

        rst = 1'b0;
        clr_inputs();
        exp_push("idle_ctrl", S_CTRL, C_NONE);
        exp_push("idle_memerr", S_MEMERR, 0);
        exp_push("idle_scnt", S_SCNT, 0);
        exp_push("idle_fcnt", S_FCNT, 0);
        step("idle");

        rdm = 5; regwritem = 1'b1; rdw = 5; regwritew = 1'b1; rs1e = 5; rs2e = 5;
        exp_push("fwd_m_a", S_FWDA, 2'b10);
        exp_push("fwd_m_b", S_FWDB, 2'b10);
        step("fwd_mem");

        regwritem = 1'b0;
        exp_push("fwd_w_a", S_FWDA, 2'b01);
        exp_push("fwd_w_b", S_FWDB, 2'b01);
        step("fwd_wb");

        regwritem = 1'b1; rdm = 0; rs1e = 0;
        exp_push("fwd_x0_a", S_FWDA, 2'b00);
        exp_push("fwd_x0w_b", S_FWDB, 2'b01);
        step("fwd_x0m");

        rdw = 0; rs2e = 0;
        exp_push("fwd_x0w", S_FWDB, 2'b00);
        exp_push("fwd_x0_ctrl", S_CTRL, C_NONE);
        step("fwd_x0w");

        clr_inputs();
        resultsrce = RES_MEM; rde = 7; rs2d = 7;
        exp_push("lw_ctrl", S_CTRL, C_LW);
        exp_push("lw_scnt0", S_SCNT, 0);
        step("lwstall");

        clr_inputs();
        exp_push("lw_after", S_CTRL, C_NONE);
        exp_push("lw_scnt1", S_SCNT, 1);
        step("lw_release");

        resultsrce = RES_MEM; rde = 0; rs1d = 0;
        exp_push("lw_x0", S_CTRL, C_NONE);
        step("lw_x0");

        resultsrce = 3'b010; rde = 7; rs2d = 7;
        exp_push("nonload", S_CTRL, C_NONE);
        step("nonload");

        clr_inputs();
        resultsrce = RES_MEM; rde = 7; rs1d = 7; pcsrce = 1'b1;
        exp_push("br_ctrl", S_CTRL, C_BR);
        exp_push("br_fcnt0", S_FCNT, 0);
        step("br_over_lw");

        clr_inputs();
        exp_push("br_fcnt1", S_FCNT, 1);
        exp_push("br_scnt", S_SCNT, 1);
        step("br_after");

        // Memory wait of three cycles with a redirect pending
        memreqm = 1'b1; memreadym = 1'b0; pcsrce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_push($sformatf("mw_ctrl%0d", i), S_CTRL, C_MW);
            exp_push($sformatf("mw_scnt%0d", i), S_SCNT, 1 + i);
            exp_push($sformatf("mw_fcnt%0d", i), S_FCNT, 1);
            step("memwait");
        end
        memreadym = 1'b1;
        exp_push("mw_ready_br", S_CTRL, C_BR);
        exp_push("mw_ready_scnt", S_SCNT, 4);
        step("mem_ready");

        clr_inputs();
        exp_push("mw_done_ctrl", S_CTRL, C_NONE);
        exp_push("mw_done_fcnt", S_FCNT, 2);
        exp_push("mw_done_err", S_MEMERR, 0);
        step("mw_done");

        // Timeout: fault visible after the fifth wait cycle, then sticky
        memreqm = 1'b1; memreadym = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_push($sformatf("to_ctrl%0d", i), S_CTRL, C_MW);
            exp_push($sformatf("to_err%0d", i), S_MEMERR, (i >= 5) ? 1 : 0);
            step("timeout");
        end
        clr_inputs();
        pcsrce = 1'b1;
        exp_push("fault_ctrl", S_CTRL, C_MW);
        exp_push("fault_err", S_MEMERR, 1);
        step("fault_hold");

        rst = 1'b1;
        exp_push("fault_rst", S_CTRL, C_RST);
        step("fault_rst");

        rst = 1'b0;
        clr_inputs();
        exp_push("post_rst_err", S_MEMERR, 0);
        exp_push("post_rst_scnt", S_SCNT, 0);
        exp_push("post_rst_fcnt", S_FCNT, 0);
        exp_push("post_rst_ctrl", S_CTRL, C_NONE);
        step("post_rst");

        // Nine consecutive load-use stalls saturate the 3-bit counter
        resultsrce = RES_MEM; rde = 9; rs1d = 9;
        for (int i = 0; i < 9; i++) begin
            exp_push($sformatf("sat_ctrl%0d", i), S_CTRL, C_LW);
            exp_push($sformatf("sat_scnt%0d", i), S_SCNT, (i > 7) ? 7 : i);
            step("sat");
        end
        clr_inputs();
        exp_push("sat_final", S_SCNT, 7);
        exp_push("sat_fcnt", S_FCNT, 0);
        step("sat_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
